ddr3_axi_arbiter: RTL and testbench
===================================

DDR3_AXI_ARBITER -- requirements
Module: ddr3_axi_arbiter

Interface
REQ-001 SHALL have parameter ID_W, default 4: AXI ID width, identical on all ports.
REQ-002 SHALL have port CLK, input, 1: single clock for all logic.
REQ-003 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_* and m1_*, input/output, AXI4 subordinate bundles: aw{valid,ready,addr[31:0],id[ID_W],len[7:0],burst[1:0]}, w{valid,ready,data[31:0],strb[3:0],last}, b{valid,ready,resp[1:0],id[ID_W]}, ar{valid,ready,addr[31:0],id[ID_W],len[7:0],burst[1:0]}, r{valid,ready,data[31:0],resp[1:0],id[ID_W],last}.
REQ-005 SHALL have port s_*, AXI4 manager bundle with the same signal set and widths as REQ-004, opposite directions, driving the DDR3 AXI controller.

Function
REQ-006 SHALL arbitrate the read path (AR/R) and the write path (AW/W/B) independently; one read and one write SHALL be in flight concurrently.
REQ-007 Write FSM states: IDLE, ADDR, DATA, RESP; read FSM states: IDLE, ADDR, DATA.
REQ-008 In IDLE, when any mN_awvalid (resp. arvalid) is high, the arbiter SHALL register the grant owner and move to ADDR on the next edge; s_awvalid/s_arvalid SHALL rise exactly 1 cycle after the request is first seen.
REQ-009 In ADDR, the owner's AW/AR fields SHALL pass to s_* unchanged; on the s_ handshake, the owner's awready/arready SHALL pulse for that same cycle; the FSM SHALL move to DATA.
REQ-010 Write DATA: owner W SHALL be forwarded combinationally, with ready passed back; on a handshake with wlast=1, the FSM SHALL move to RESP.
REQ-011 Write RESP: s_b SHALL be routed to the owner; on the B handshake, the FSM SHALL return to IDLE.
REQ-012 Read DATA: s_r SHALL be routed to the owner; on an R handshake with rlast=1, the FSM SHALL return to IDLE.
REQ-013 Responses SHALL be routed by the owner register, not by ID; IDs SHALL pass unmodified.
REQ-014 The non-owner master SHALL see all ready and valid outputs at 0 on that path; its request SHALL be held pending, never dropped.
REQ-015 Simultaneous requests in IDLE SHALL be resolved per REQ-021/022.
REQ-016 A request that deasserts before grant SHALL have no effect; the registered grant SHALL use the sampled valid.
REQ-017 W beats arriving before the AW handshake SHALL be stalled (wready=0).
REQ-018 A burst of len=0 (single beat) SHALL complete DATA in one handshake.

Reset
REQ-019 On RST_N low, both FSMs SHALL go to IDLE asynchronously, and the grant owners and round-robin pointer SHALL go to 0.
REQ-020 On RST_N low, every valid/ready output on m0_*, m1_*, s_* SHALL be 0; data outputs SHALL be 0. A transaction interrupted by reset SHALL be abandoned; the DDR3 controller is reset by the same signal.

Configuration
REQ-021 With ARB_ROUND_ROBIN_EN defined, each path SHALL keep a last-winner bit: on contention the other master wins, and the bit SHALL update on each grant.
REQ-022 Without ARB_ROUND_ROBIN_EN, m0 SHALL always win contention (fixed priority), and no pointer state SHALL exist.

Verification
REQ-023 m0 ar{addr=0x100,len=3}, m1 idle -> s_arvalid 1 cycle later, 4 R beats to m0, m1_rvalid=0 throughout, IDLE after rlast.
REQ-024 m0 and m1 assert arvalid on the same cycle, RR build -> m0 first, then m1; repeat -> m1 first; fixed build -> m0 both times.
REQ-025 m0 write len=1 concurrent with m1 read len=7 -> both complete with no stall from the other path; bresp and bid routed to m0.
REQ-026 m1 asserts wvalid 3 cycles before awvalid -> m1_wready=0 until the AW handshake; data lands in the correct order.
REQ-027 RST_N low in write DATA after 1 of 4 beats -> all valids/readies 0 immediately; after release, a new m0 write completes normally.

Source files
------------

// File: rtl/ddr3_axi_arbiter.sv
// Two-master AXI4 arbiter for one DDR3 controller; read and write paths arbitrate independently.
// Latency: s_awvalid/s_arvalid rise one cycle after a request is seen; W/B/R are combinational pass-through.
// Backpressure: the non-owner stays stalled with all readies at 0; owner ready/valid pass straight through.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise m0 has fixed priority.
module ddr3_axi_arbiter #(
   parameter int ID_W = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   // master 0
   input  logic            m0_awvalid,
   output logic            m0_awready,
   input  logic [31:0]     m0_awaddr,
   input  logic [ID_W-1:0] m0_awid,
   input  logic [7:0]      m0_awlen,
   input  logic [1:0]      m0_awburst,
   input  logic            m0_wvalid,
   output logic            m0_wready,
   input  logic [31:0]     m0_wdata,
   input  logic [3:0]      m0_wstrb,
   input  logic            m0_wlast,
   output logic            m0_bvalid,
   input  logic            m0_bready,
   output logic [1:0]      m0_bresp,
   output logic [ID_W-1:0] m0_bid,
   input  logic            m0_arvalid,
   output logic            m0_arready,
   input  logic [31:0]     m0_araddr,
   input  logic [ID_W-1:0] m0_arid,
   input  logic [7:0]      m0_arlen,
   input  logic [1:0]      m0_arburst,
   output logic            m0_rvalid,
   input  logic            m0_rready,
   output logic [31:0]     m0_rdata,
   output logic [1:0]      m0_rresp,
   output logic [ID_W-1:0] m0_rid,
   output logic            m0_rlast,
   // master 1
   input  logic            m1_awvalid,
   output logic            m1_awready,
   input  logic [31:0]     m1_awaddr,
   input  logic [ID_W-1:0] m1_awid,
   input  logic [7:0]      m1_awlen,
   input  logic [1:0]      m1_awburst,
   input  logic            m1_wvalid,
   output logic            m1_wready,
   input  logic [31:0]     m1_wdata,
   input  logic [3:0]      m1_wstrb,
   input  logic            m1_wlast,
   output logic            m1_bvalid,
   input  logic            m1_bready,
   output logic [1:0]      m1_bresp,
   output logic [ID_W-1:0] m1_bid,
   input  logic            m1_arvalid,
   output logic            m1_arready,
   input  logic [31:0]     m1_araddr,
   input  logic [ID_W-1:0] m1_arid,
   input  logic [7:0]      m1_arlen,
   input  logic [1:0]      m1_arburst,
   output logic            m1_rvalid,
   input  logic            m1_rready,
   output logic [31:0]     m1_rdata,
   output logic [1:0]      m1_rresp,
   output logic [ID_W-1:0] m1_rid,
   output logic            m1_rlast,
   // DDR3 controller
   output logic            s_awvalid,
   input  logic            s_awready,
   output logic [31:0]     s_awaddr,
   output logic [ID_W-1:0] s_awid,
   output logic [7:0]      s_awlen,
   output logic [1:0]      s_awburst,
   output logic            s_wvalid,
   input  logic            s_wready,
   output logic [31:0]     s_wdata,
   output logic [3:0]      s_wstrb,
   output logic            s_wlast,
   input  logic            s_bvalid,
   output logic            s_bready,
   input  logic [1:0]      s_bresp,
   input  logic [ID_W-1:0] s_bid,
   output logic            s_arvalid,
   input  logic            s_arready,
   output logic [31:0]     s_araddr,
   output logic [ID_W-1:0] s_arid,
   output logic [7:0]      s_arlen,
   output logic [1:0]      s_arburst,
   input  logic            s_rvalid,
   output logic            s_rready,
   input  logic [31:0]     s_rdata,
   input  logic [1:0]      s_rresp,
   input  logic [ID_W-1:0] s_rid,
   input  logic            s_rlast
);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

   wr_state_e wr_st_q, wr_st_d;
   rd_state_e rd_st_q, rd_st_d;
   logic      wr_own_q, wr_own_d;   // 1 = m1 owns the path
   logic      rd_own_q, rd_own_d;
   logic      wr_pick, rd_pick;

`ifdef ARB_ROUND_ROBIN_EN
   // Holds the master that wins the next contention, i.e. the complement of the last winner.
   logic wr_ptr_q, wr_ptr_d;
   logic rd_ptr_q, rd_ptr_d;

   assign wr_pick = (m0_awvalid && m1_awvalid) ? wr_ptr_q : m1_awvalid;
   assign rd_pick = (m0_arvalid && m1_arvalid) ? rd_ptr_q : m1_arvalid;
`else
   assign wr_pick = m1_awvalid && !m0_awvalid;
   assign rd_pick = m1_arvalid && !m0_arvalid;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_st_q  <= W_IDLE;
         rd_st_q  <= R_IDLE;
         wr_own_q <= 1'b0;
         rd_own_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
`endif
      end else begin
         wr_st_q  <= wr_st_d;
         rd_st_q  <= rd_st_d;
         wr_own_q <= wr_own_d;
         rd_own_q <= rd_own_d;
`ifdef ARB_ROUND_ROBIN_EN
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
`endif
      end
   end

   always_comb begin
      wr_st_d  = wr_st_q;
      wr_own_d = wr_own_q;
`ifdef ARB_ROUND_ROBIN_EN
      wr_ptr_d = wr_ptr_q;
`endif
      case (wr_st_q)
         W_IDLE: if (m0_awvalid || m1_awvalid) begin
            wr_own_d = wr_pick;
`ifdef ARB_ROUND_ROBIN_EN
            wr_ptr_d = ~wr_pick;
`endif
            wr_st_d  = W_ADDR;
         end
         W_ADDR:  if (s_awready) wr_st_d = W_DATA;
         W_DATA:  if (s_wvalid && s_wready && s_wlast) wr_st_d = W_RESP;
         W_RESP:  if (s_bvalid && s_bready) wr_st_d = W_IDLE;
         default: wr_st_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_st_d  = rd_st_q;
      rd_own_d = rd_own_q;
`ifdef ARB_ROUND_ROBIN_EN
      rd_ptr_d = rd_ptr_q;
`endif
      case (rd_st_q)
         R_IDLE: if (m0_arvalid || m1_arvalid) begin
            rd_own_d = rd_pick;
`ifdef ARB_ROUND_ROBIN_EN
            rd_ptr_d = ~rd_pick;
`endif
            rd_st_d  = R_ADDR;
         end
         R_ADDR:  if (s_arready) rd_st_d = R_DATA;
         R_DATA:  if (s_rvalid && s_rready && s_rlast) rd_st_d = R_IDLE;
         default: rd_st_d = R_IDLE;
      endcase
   end

   // Write-path steering: everything outside the active phase is held at 0.
   always_comb begin
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_awid     = '0;
      s_awlen    = '0;
      s_awburst  = '0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wlast    = 1'b0;
      s_bready   = 1'b0;
      m0_awready = 1'b0;
      m1_awready = 1'b0;
      m0_wready  = 1'b0;
      m1_wready  = 1'b0;
      m0_bvalid  = 1'b0;
      m1_bvalid  = 1'b0;
      m0_bresp   = '0;
      m1_bresp   = '0;
      m0_bid     = '0;
      m1_bid     = '0;
      case (wr_st_q)
         W_ADDR: begin
            s_awvalid = 1'b1;
            s_awaddr  = wr_own_q ? m1_awaddr  : m0_awaddr;
            s_awid    = wr_own_q ? m1_awid    : m0_awid;
            s_awlen   = wr_own_q ? m1_awlen   : m0_awlen;
            s_awburst = wr_own_q ? m1_awburst : m0_awburst;
            m0_awready = !wr_own_q && s_awready;
            m1_awready =  wr_own_q && s_awready;
         end
         W_DATA: begin
            s_wvalid  = wr_own_q ? m1_wvalid : m0_wvalid;
            s_wdata   = wr_own_q ? m1_wdata  : m0_wdata;
            s_wstrb   = wr_own_q ? m1_wstrb  : m0_wstrb;
            s_wlast   = wr_own_q ? m1_wlast  : m0_wlast;
            m0_wready = !wr_own_q && s_wready;
            m1_wready =  wr_own_q && s_wready;
         end
         W_RESP: begin
            s_bready = wr_own_q ? m1_bready : m0_bready;
            if (wr_own_q) begin
               m1_bvalid = s_bvalid;
               m1_bresp  = s_bresp;
               m1_bid    = s_bid;
            end else begin
               m0_bvalid = s_bvalid;
               m0_bresp  = s_bresp;
               m0_bid    = s_bid;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_arid     = '0;
      s_arlen    = '0;
      s_arburst  = '0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      m0_rdata   = '0;
      m1_rdata   = '0;
      m0_rresp   = '0;
      m1_rresp   = '0;
      m0_rid     = '0;
      m1_rid     = '0;
      m0_rlast   = 1'b0;
      m1_rlast   = 1'b0;
      case (rd_st_q)
         R_ADDR: begin
            s_arvalid = 1'b1;
            s_araddr  = rd_own_q ? m1_araddr  : m0_araddr;
            s_arid    = rd_own_q ? m1_arid    : m0_arid;
            s_arlen   = rd_own_q ? m1_arlen   : m0_arlen;
            s_arburst = rd_own_q ? m1_arburst : m0_arburst;
            m0_arready = !rd_own_q && s_arready;
            m1_arready =  rd_own_q && s_arready;
         end
         R_DATA: begin
            s_rready = rd_own_q ? m1_rready : m0_rready;
            if (rd_own_q) begin
               m1_rvalid = s_rvalid;
               m1_rdata  = s_rdata;
               m1_rresp  = s_rresp;
               m1_rid    = s_rid;
               m1_rlast  = s_rlast;
            end else begin
               m0_rvalid = s_rvalid;
               m0_rdata  = s_rdata;
               m0_rresp  = s_rresp;
               m0_rid    = s_rid;
               m0_rlast  = s_rlast;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ddr3_axi_arbiter.sv
// Directed bench for ddr3_axi_arbiter: behavioural DDR3-side responder plus per-channel scoreboards.
module tb_ddr3_axi_arbiter;
   localparam int ID_W = 4;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   logic            m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast, m0_bvalid, m0_bready;
   logic            m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
   logic [31:0]     m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
   logic [ID_W-1:0] m0_awid, m0_bid, m0_arid, m0_rid;
   logic [7:0]      m0_awlen, m0_arlen;
   logic [1:0]      m0_awburst, m0_bresp, m0_arburst, m0_rresp;
   logic [3:0]      m0_wstrb;
   logic            m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
   logic            m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
   logic [31:0]     m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
   logic [ID_W-1:0] m1_awid, m1_bid, m1_arid, m1_rid;
   logic [7:0]      m1_awlen, m1_arlen;
   logic [1:0]      m1_awburst, m1_bresp, m1_arburst, m1_rresp;
   logic [3:0]      m1_wstrb;
   logic            s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [31:0]     s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [ID_W-1:0] s_awid, s_bid, s_arid, s_rid;
   logic [7:0]      s_awlen, s_arlen;
   logic [1:0]      s_awburst, s_bresp, s_arburst, s_rresp;
   logic [3:0]      s_wstrb;

   ddr3_axi_arbiter #(.ID_W(ID_W)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid),
      .m0_awlen(m0_awlen), .m0_awburst(m0_awburst), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_bvalid(m0_bvalid),
      .m0_bready(m0_bready), .m0_bresp(m0_bresp), .m0_bid(m0_bid), .m0_arvalid(m0_arvalid),
      .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
      .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
      .m0_rresp(m0_rresp), .m0_rid(m0_rid), .m0_rlast(m0_rlast),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
      .m1_awlen(m1_awlen), .m1_awburst(m1_awburst), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid),
      .m1_bready(m1_bready), .m1_bresp(m1_bresp), .m1_bid(m1_bid), .m1_arvalid(m1_arvalid),
      .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
      .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
      .m1_rresp(m1_rresp), .m1_rid(m1_rid), .m1_rlast(m1_rlast),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
      .s_awlen(s_awlen), .s_awburst(s_awburst), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid),
      .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid), .s_arvalid(s_arvalid),
      .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
      .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast)
   );

   logic [14:0] vr_vec;
   assign vr_vec = {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                    m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid,
                    m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid};

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int h0, h1, start;

   logic [38:0] exp_r0[$], exp_r1[$];   // {last, resp, id, data}
   logic [5:0]  exp_b0[$], exp_b1[$];   // {id, resp}
   logic [36:0] exp_w[$];               // {last, strb, data}
   logic [45:0] exp_aw[$];              // {addr, id, len, burst}

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Master-side ready patterns give R and B some backpressure.
   initial forever begin
      @(posedge CLK);
      #1;
      m0_rready = (cyc % 3) != 0;
      m1_rready = 1'b1;
      m0_bready = (cyc % 2) == 0;
      m1_bready = 1'b1;
   end

   // DDR3 responder: rdata = araddr + beat, rresp = beat[1:0], bresp = EXOKAY, ids echoed.
   initial begin
      logic aw_hs, w_hs, w_last, b_hs, ar_hs, r_hs;
      logic [ID_W-1:0] awid_s, arid_s, wr_id;
      logic [31:0] araddr_s, rd_addr;
      logic [7:0] arlen_s, rd_len, rd_beat;
      s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
      s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rid = 0; s_rlast = 0;
      wr_id = 0; rd_addr = 0; rd_len = 0; rd_beat = 0;
      forever begin
         @(negedge CLK);
         aw_hs = s_awvalid && s_awready; awid_s = s_awid;
         w_hs = s_wvalid && s_wready;    w_last = s_wlast;
         b_hs = s_bvalid && s_bready;
         ar_hs = s_arvalid && s_arready; arid_s = s_arid; araddr_s = s_araddr; arlen_s = s_arlen;
         r_hs = s_rvalid && s_rready;
         @(posedge CLK);
         #1;
         if (!RST_N) begin
            s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0; s_rlast = 0;
         end else begin
            s_awready = 1; s_wready = 1; s_arready = 1;
            if (aw_hs) wr_id = awid_s;
            if (b_hs) s_bvalid = 0;
            if (w_hs && w_last) begin
               s_bvalid = 1; s_bid = wr_id; s_bresp = 2'b01;
            end
            if (r_hs) begin
               if (s_rlast) s_rvalid = 0;
               else begin
                  rd_beat = rd_beat + 8'd1;
                  s_rdata = rd_addr + 32'(rd_beat);
                  s_rresp = rd_beat[1:0];
                  s_rlast = (rd_beat == rd_len);
               end
            end
            if (ar_hs) begin
               rd_addr = araddr_s; rd_len = arlen_s; rd_beat = 0;
               s_rvalid = 1; s_rdata = araddr_s; s_rid = arid_s; s_rresp = 0; s_rlast = (arlen_s == 0);
            end
         end
      end
   end

   // Scoreboard monitors: every handshake pops and compares one expected entry.
   initial forever begin
      @(negedge CLK);
      if (m0_rvalid && m0_rready) begin
         if (exp_r0.size() == 0) chk("r0_unexpected", 1, 0);
         else chk("r0_beat", {m0_rlast, m0_rresp, m0_rid, m0_rdata}, exp_r0.pop_front());
      end
      if (m1_rvalid && m1_rready) begin
         if (exp_r1.size() == 0) chk("r1_unexpected", 1, 0);
         else chk("r1_beat", {m1_rlast, m1_rresp, m1_rid, m1_rdata}, exp_r1.pop_front());
      end
      if (m0_bvalid && m0_bready) begin
         if (exp_b0.size() == 0) chk("b0_unexpected", 1, 0);
         else chk("b0_resp", {m0_bid, m0_bresp}, exp_b0.pop_front());
      end
      if (m1_bvalid && m1_bready) begin
         if (exp_b1.size() == 0) chk("b1_unexpected", 1, 0);
         else chk("b1_resp", {m1_bid, m1_bresp}, exp_b1.pop_front());
      end
      if (s_wvalid && s_wready) begin
         if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
         else chk("w_beat", {s_wlast, s_wstrb, s_wdata}, exp_w.pop_front());
      end
      if (s_awvalid && s_awready) begin
         if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
         else chk("aw_fields", {s_awaddr, s_awid, s_awlen, s_awburst}, exp_aw.pop_front());
      end
   end

   task automatic ar_req(input int m, input logic [31:0] addr, input logic [ID_W-1:0] id,
                         input logic [7:0] len, output int hs);
      for (int i = 0; i <= int'(len); i++) begin
         logic [31:0] ib;
         logic [38:0] e;
         ib = i;
         e = {(i == int'(len)), ib[1:0], id, addr + ib};
         if (m == 0) exp_r0.push_back(e); else exp_r1.push_back(e);
      end
      if (m == 0) begin
         m0_arvalid = 1; m0_araddr = addr; m0_arid = id; m0_arlen = len; m0_arburst = 2'b01;
      end else begin
         m1_arvalid = 1; m1_araddr = addr; m1_arid = id; m1_arlen = len; m1_arburst = 2'b01;
      end
      hs = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge CLK);
         if ((m == 0) ? m0_arready : m1_arready) begin
            hs = cyc;
            break;
         end
      end
      if (hs < 0) chk("ar_timeout", 1, 0);
      @(posedge CLK);
      #1;
      if (m == 0) m0_arvalid = 0; else m1_arvalid = 0;
   endtask

   task automatic aw_req(input int m, input logic [31:0] addr, input logic [ID_W-1:0] id,
                         input logic [7:0] len, output int hs);
      exp_aw.push_back({addr, id, len, 2'b01});
      if (m == 0) begin
         m0_awvalid = 1; m0_awaddr = addr; m0_awid = id; m0_awlen = len; m0_awburst = 2'b01;
      end else begin
         m1_awvalid = 1; m1_awaddr = addr; m1_awid = id; m1_awlen = len; m1_awburst = 2'b01;
      end
      hs = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge CLK);
         if ((m == 0) ? m0_awready : m1_awready) begin
            hs = cyc;
            break;
         end
      end
      if (hs < 0) chk("aw_timeout", 1, 0);
      @(posedge CLK);
      #1;
      if (m == 0) m0_awvalid = 0; else m1_awvalid = 0;
   endtask

   task automatic w_send(input int m, input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] ib;
         logic [3:0] st;
         logic ok;
         ib = i;
         st = ib[3:0] ^ 4'hF;
         exp_w.push_back({(i == n - 1), st, base + ib});
         if (m == 0) begin
            m0_wvalid = 1; m0_wdata = base + ib; m0_wstrb = st; m0_wlast = (i == n - 1);
         end else begin
            m1_wvalid = 1; m1_wdata = base + ib; m1_wstrb = st; m1_wlast = (i == n - 1);
         end
         ok = 0;
         for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if ((m == 0) ? m0_wready : m1_wready) begin
               ok = 1;
               break;
            end
         end
         if (!ok) chk("w_timeout", 1, 0);
         @(posedge CLK);
         #1;
      end
      if (m == 0) m0_wvalid = 0; else m1_wvalid = 0;
   endtask

   task automatic wait_drain();
      int left;
      left = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge CLK);
         left = exp_r0.size() + exp_r1.size() + exp_b0.size() + exp_b1.size() + exp_w.size() + exp_aw.size();
         if (left == 0) break;
      end
      chk("drain_outstanding", left, 0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      m0_awvalid = 0; m0_awaddr = 0; m0_awid = 0; m0_awlen = 0; m0_awburst = 0;
      m0_wvalid = 0; m0_wdata = 0; m0_wstrb = 0; m0_wlast = 0;
      m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arburst = 0;
      m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_awburst = 0;
      m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0;
      m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arburst = 0;
      m0_rready = 1; m1_rready = 1; m0_bready = 1; m1_bready = 1;

      // Reset state: every valid/ready and data output at 0.
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_vld_rdy", vr_vec, 0);
      chk("rst_s_data", {s_awaddr, s_wdata}, 0);
      chk("rst_m_rdata", {m0_rdata, m1_rdata}, 0);
      #2 RST_N = 1;
      repeat (2) @(posedge CLK);
      #1;

      // Single m0 read, len=3: s_arvalid one cycle after the request.
      start = cyc;
      fork
         ar_req(0, 32'h100, 4'h3, 8'd3, h0);
         begin
            @(negedge CLK);
            chk("ar_lat_cycle0", s_arvalid, 0);
            @(negedge CLK);
            chk("ar_lat_cycle1", s_arvalid, 1);
            chk("ar_addr_pass", s_araddr, 32'h100);
            chk("ar_ready_owner", {m0_arready, m1_arready}, 2'b10);
         end
      join
      chk("ar_hs_latency", h0 - start, 1);
      wait_drain();

      // Contention on AR, then a solo m0 read, then contention again.
      start = cyc;
      fork
         ar_req(0, 32'h200, 4'h1, 8'd1, h0);
         ar_req(1, 32'h300, 4'h2, 8'd0, h1);
      join
      chk("cont1_m0_first", h0 < h1, 1);
      chk("cont1_m0_latency", h0 - start, 1);
      wait_drain();
      ar_req(0, 32'h400, 4'h5, 8'd0, h0);
      wait_drain();
      fork
         ar_req(0, 32'h500, 4'h6, 8'd2, h0);
         ar_req(1, 32'h600, 4'h7, 8'd1, h1);
      join
`ifdef ARB_ROUND_ROBIN_EN
      chk("cont2_m1_first", h1 < h0, 1);
`else
      chk("cont2_m0_first", h0 < h1, 1);
`endif
      wait_drain();

      // m0 write len=1 concurrent with m1 read len=7.
      exp_b0.push_back({4'h9, 2'b01});
      start = cyc;
      fork
         aw_req(0, 32'h1000, 4'h9, 8'd1, h0);
         w_send(0, 32'hA000, 2);
         ar_req(1, 32'h2000, 4'hB, 8'd7, h1);
      join
      chk("cc_aw_nostall", h0 - start, 1);
      chk("cc_ar_nostall", h1 - start, 1);
      wait_drain();

      // m1 W beats three cycles ahead of AW: stalled until the AW handshake.
      exp_b1.push_back({4'hC, 2'b01});
      fork
         w_send(1, 32'hB000, 2);
         begin
            repeat (3) begin
               @(posedge CLK);
               #1;
            end
            aw_req(1, 32'h3000, 4'hC, 8'd1, h0);
         end
         begin
            for (int k = 0; k < 5; k++) begin
               @(negedge CLK);
               chk("w_early_stall", m1_wready, 0);
            end
         end
      join
      wait_drain();

      // Reset in write DATA after one of four beats.
      aw_req(0, 32'h4000, 4'h1, 8'd3, h0);
      exp_w.push_back({1'b0, 4'hF, 32'hC000});
      m0_wvalid = 1; m0_wdata = 32'hC000; m0_wstrb = 4'hF; m0_wlast = 0;
      @(negedge CLK);
      chk("rst_w_beat0_ready", m0_wready, 1);
      @(posedge CLK);
      #1;
      m0_wdata = 32'hC001; m0_wstrb = 4'hE;
      #2 RST_N = 0;
      #1;
      chk("rst_mid_vld_rdy", vr_vec, 0);
      chk("rst_mid_data", {s_wdata, s_awaddr}, 0);
      m0_wvalid = 0;
      repeat (2) @(posedge CLK);
      #3 RST_N = 1;
      @(posedge CLK);
      #1;
      exp_b0.push_back({4'h2, 2'b01});
      fork
         aw_req(0, 32'h5000, 4'h2, 8'd3, h0);
         w_send(0, 32'hD000, 4);
      join
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
